// File: rtl/exec_serial_shifter.sv
// Bit-serial SLL/SRL/SRA unit for the execute stage.
// It holds the decode/execute pipe register through `stall` while it shifts one bit
// per clock. It then presents a registered result for exactly one cycle.
module exec_serial_shifter #(
  parameter int unsigned DATAPATH_WIDTH = 64,
  parameter int unsigned SHAMT_WIDTH    = 5,
  parameter logic [3:0]  ALU_SLL        = 4'd5,
  parameter logic [3:0]  ALU_SRL        = 4'd6,
  parameter logic [3:0]  ALU_SRA        = 4'd7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      op_valid,
  input  logic [3:0]                alu_ctrl,
  input  logic [DATAPATH_WIDTH-1:0] operand,
  input  logic [SHAMT_WIDTH-1:0]    shamt,
  input  logic                      flush,
  output logic                      stall,
  output logic                      busy,
  output logic [DATAPATH_WIDTH-1:0] result,
  output logic                      result_valid
);

  localparam logic [SHAMT_WIDTH-1:0] CountZero = '0;
  localparam logic [SHAMT_WIDTH-1:0] CountOne  = SHAMT_WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // ShSll must encode as zero so that reset clears the latched type to 0.
  typedef enum logic [1:0] {
    ShSll,
    ShSrl,
    ShSra
  } shift_e;

  state_e                    state_q, state_d;
  logic [SHAMT_WIDTH-1:0]    count_q, count_d;
  logic [DATAPATH_WIDTH-1:0] shreg_q, shreg_d;
  shift_e                    type_q, type_d;
  logic [DATAPATH_WIDTH-1:0] result_q, result_d;
  logic                      result_valid_q, result_valid_d;
  logic                      busy_q, busy_d;

  logic                      is_shift;
  shift_e                    type_in;
  logic [DATAPATH_WIDTH-1:0] shreg_step;

  // Decode whether the pipe register holds a shift instruction, and which kind of shift.
  always_comb begin
    is_shift = 1'b0;
    type_in  = ShSll;
    if (alu_ctrl == ALU_SLL) begin
      is_shift = op_valid;
      type_in  = ShSll;
    end else if (alu_ctrl == ALU_SRL) begin
      is_shift = op_valid;
      type_in  = ShSrl;
    end else if (alu_ctrl == ALU_SRA) begin
      is_shift = op_valid;
      type_in  = ShSra;
    end
  end

  // Compute the one-bit shift of the working register for the latched shift type.
  always_comb begin
    shreg_step = shreg_q;
    unique case (type_q)
      ShSll:   shreg_step = {shreg_q[DATAPATH_WIDTH-2:0], 1'b0};
      ShSrl:   shreg_step = {1'b0, shreg_q[DATAPATH_WIDTH-1:1]};
      ShSra:   shreg_step = {shreg_q[DATAPATH_WIDTH-1], shreg_q[DATAPATH_WIDTH-1:1]};
      default: shreg_step = shreg_q;
    endcase
  end

  // Hold the FSM state; reset returns it to idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Compute the next state. Flush aborts from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (is_shift) begin
          state_d = (shamt == CountZero) ? StDone : StShift;
        end
      end
      StShift: begin
        // count never reaches 0 inside SHIFT, but <= keeps a corrupted count from hanging
        if (count_q <= CountOne) begin
          state_d = StDone;
        end
      end
      // DONE always returns to idle, so the held instruction is not accepted a second time
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  // Compute the combinational stall for the pipe enable (pipe en = ~stall).
  always_comb begin
    stall = 1'b0;
    unique case (state_q)
      StIdle:  stall = is_shift;
      StShift: stall = 1'b1;
      StDone:  stall = 1'b0;
      default: stall = 1'b0;
    endcase
    // A flushed or resetting stage must never hold the pipe
    if (flush || reset) begin
      stall = 1'b0;
    end
  end

  // Compute next values for the datapath: load at accept, then one bit per SHIFT cycle.
  always_comb begin
    count_d = count_q;
    shreg_d = shreg_q;
    type_d  = type_q;
    unique case (state_q)
      StIdle: begin
        if (is_shift && !flush) begin
          shreg_d = operand;
          count_d = shamt;
          type_d  = type_in;
        end
      end
      StShift: begin
        if (count_q != CountZero) begin
          shreg_d = shreg_step;
          count_d = count_q - CountOne;
        end
      end
      default: ;
    endcase
    if (flush) begin
      count_d = CountZero;
    end
  end

  // Compute next values for the registered outputs from the upcoming state.
  always_comb begin
    result_valid_d = (state_d == StDone);
    busy_d         = (state_d == StShift);
    // result holds its last value once DONE has passed; only result_valid qualifies it
    result_d       = (state_d == StDone) ? shreg_d : result_q;
  end

  // Hold the datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q        <= CountZero;
      shreg_q        <= '0;
      type_q         <= ShSll;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      count_q        <= count_d;
      shreg_q        <= shreg_d;
      type_q         <= type_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_exec_serial_shifter.sv
// Directed bench for exec_serial_shifter: table of single shifts plus corner sequences.
module tb_exec_serial_shifter;

  localparam int         W   = 64;
  localparam int         SW  = 5;
  localparam logic [3:0] SLL = 4'd5;
  localparam logic [3:0] SRL = 4'd6;
  localparam logic [3:0] SRA = 4'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid;
  logic [3:0]    alu_ctrl;
  logic [W-1:0]  operand;
  logic [SW-1:0] shamt;
  logic          flush;
  logic          stall;
  logic          busy;
  logic [W-1:0]  result;
  logic          result_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]    ctrl;
    logic [W-1:0]  opnd;
    logic [SW-1:0] sh;
    logic [W-1:0]  exp_res;
    int            exp_stalls;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  exec_serial_shifter dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .alu_ctrl     (alu_ctrl),
    .operand      (operand),
    .shamt        (shamt),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one shift, count stall and busy cycles until result_valid, then release the op.
  task automatic run_op(input vec_t v, input string tag);
    int stalls;
    int busys;
    bit seen;
    stalls   = 0;
    busys    = 0;
    seen     = 1'b0;
    op_valid = 1'b1;
    alu_ctrl = v.ctrl;
    operand  = v.opnd;
    shamt    = v.sh;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      if (stall) stalls++;
      if (busy) busys++;
      step();
    end
    chk({tag, " result_valid seen"}, W'(seen), W'(1));
    chk({tag, " stall cycles"}, W'(stalls), W'(v.exp_stalls));
    chk({tag, " busy cycles"}, W'(busys), W'(v.sh));
    chk({tag, " result"}, result, v.exp_res);
    chk({tag, " stall in done"}, W'(stall), W'(0));
    op_valid = 1'b0;
    step();
    chk({tag, " result_valid after done"}, W'(result_valid), W'(0));
    chk({tag, " busy after done"}, W'(busy), W'(0));
    chk({tag, " result held"}, result, v.exp_res);
  endtask

  initial begin
    int cnt;
    int pulses;
    int pulse_cyc[4];
    logic [W-1:0] pulse_res[4];

    reset    = 1'b1;
    op_valid = 1'b0;
    flush    = 1'b0;
    alu_ctrl = 4'd0;
    operand  = '0;
    shamt    = '0;

    vecs[0] = '{SLL, 64'h1, 5'd4, 64'h10, 5};
    vecs[1] = '{SRA, 64'h8000_0000_0000_0000, 5'd31, 64'hFFFF_FFFF_0000_0000, 32};
    vecs[2] = '{SRL, 64'h8000_0000_0000_0000, 5'd31, 64'h0000_0001_0000_0000, 32};
    vecs[3] = '{SRL, 64'hDEAD, 5'd0, 64'hDEAD, 1};
    vecs[4] = '{SRA, 64'h7000_0000_0000_0000, 5'd4, 64'h0700_0000_0000_0000, 5};
    vecs[5] = '{SLL, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 2};
    vecs[6] = '{SRA, 64'hF0, 5'd4, 64'h0F, 5};

    step();
    step();
    chk("reset stall", W'(stall), W'(0));
    chk("reset busy", W'(busy), W'(0));
    chk("reset result_valid", W'(result_valid), W'(0));
    chk("reset result", result, W'(0));
    reset = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // A non-shift alu_ctrl with op_valid high must never stall.
    op_valid = 1'b1;
    alu_ctrl = 4'd2;
    operand  = 64'h1234;
    shamt    = 5'd9;
    cnt      = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (stall || busy || result_valid) cnt++;
      step();
    end
    chk("non-shift never stalls", W'(cnt), W'(0));
    op_valid = 1'b0;
    step();

    // Flush in SHIFT cycle 3 of SLL shamt=10.
    op_valid = 1'b1;
    alu_ctrl = SLL;
    operand  = 64'h1;
    shamt    = 5'd10;
    step();
    step();
    step();
    flush = 1'b1;
    #1;
    chk("flush stall forced low", W'(stall), W'(0));
    chk("flush busy before edge", W'(busy), W'(1));
    step();
    flush    = 1'b0;
    op_valid = 1'b0;
    #1;
    chk("after flush busy", W'(busy), W'(0));
    chk("after flush stall", W'(stall), W'(0));
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (result_valid) cnt++;
      step();
    end
    chk("flush no result_valid", W'(cnt), W'(0));

    // Reset in SHIFT cycle 5 of SLL shamt=20 with op_valid still high.
    op_valid = 1'b1;
    alu_ctrl = SLL;
    operand  = 64'h1;
    shamt    = 5'd20;
    for (int c = 0; c < 5; c++) step();
    chk("pre-reset busy", W'(busy), W'(1));
    reset = 1'b1;
    #1;
    chk("async reset stall", W'(stall), W'(0));
    chk("async reset busy", W'(busy), W'(0));
    chk("async reset result_valid", W'(result_valid), W'(0));
    chk("async reset result", result, W'(0));
    step();
    op_valid = 1'b0;
    reset    = 1'b0;
    step();
    chk("post-reset idle stall", W'(stall), W'(0));
    chk("post-reset idle result_valid", W'(result_valid), W'(0));
    run_op('{SLL, 64'h3, 5'd2, 64'hC, 3}, "post-reset");

    // Back-to-back SLL shamt=2 of 3 and 5, with garbage inputs during SHIFT.
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        op_valid = 1'b1; alu_ctrl = SLL; operand = 64'h3; shamt = 5'd2;
      end else if (i == 1 || i == 5) begin
        alu_ctrl = SRA; operand = 64'hFFFF; shamt = 5'd7;
      end else if (i == 4) begin
        alu_ctrl = SLL; operand = 64'h5; shamt = 5'd2;
      end else if (i == 8) begin
        op_valid = 1'b0;
      end
      #1;
      if (result_valid && pulses < 4) begin
        pulse_cyc[pulses] = i;
        pulse_res[pulses] = result;
        pulses++;
      end
      step();
    end
    chk("b2b pulse count", W'(pulses), W'(2));
    if (pulses >= 2) begin
      chk("b2b first result", pulse_res[0], 64'd12);
      chk("b2b second result", pulse_res[1], 64'd20);
      chk("b2b idle cycles between pulses", W'(pulse_cyc[1] - pulse_cyc[0] - 1), W'(3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
